// File: rtl/sbqm_occupancy_counter.sv
// Bank queue occupancy counter: synchronised entry/exit photocells, saturating count, status and sticky error flags.
// Optional peak-occupancy tracking is enabled by defining SBQM_PEAK_TRACK_EN.
`timescale 1ns/1ps
module sbqm_occupancy_counter #(
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned MAX_COUNT = 7,
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_sensor,
  input  logic             leave_sensor,
  input  logic             err_clr,
  output logic [CNT_W-1:0] p_count,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             almost_full,
  output logic             enter_evt,
  output logic             leave_evt,
  output logic             overflow_err,
  output logic             underflow_err
`ifdef SBQM_PEAK_TRACK_EN
  ,
  output logic [CNT_W-1:0] peak_count
`endif
);

  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [EXT_W-1:0] MAX_EXT   = EXT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic r_ent_s1, r_ent_s2, r_ent_s3;
  logic r_lv_s1, r_lv_s2, r_lv_s3;
  logic w_ent_evt, w_lv_evt;

  logic [CNT_W-1:0] r_count;
  logic             r_full, r_empty, r_afull;
  logic             r_enter_evt, r_leave_evt;
  logic             r_ovf, r_unf;

  logic [EXT_W-1:0] w_cnt_ext, w_inc, w_dec;
  logic [CNT_W-1:0] w_next;
  logic             w_enter_acc, w_leave_acc, w_ovf_set, w_unf_set;

  // Two-flop synchronisers plus a history flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent_s1 <= 1'b0;
      r_ent_s2 <= 1'b0;
      r_ent_s3 <= 1'b0;
      r_lv_s1  <= 1'b0;
      r_lv_s2  <= 1'b0;
      r_lv_s3  <= 1'b0;
    end else begin
      r_ent_s1 <= enter_sensor;
      r_ent_s2 <= r_ent_s1;
      r_ent_s3 <= r_ent_s2;
      r_lv_s1  <= leave_sensor;
      r_lv_s2  <= r_lv_s1;
      r_lv_s3  <= r_lv_s2;
    end
  end

  assign w_ent_evt = r_ent_s2 & ~r_ent_s3;
  assign w_lv_evt  = r_lv_s2 & ~r_lv_s3;

  // Next-count decision; arithmetic is one bit wider so carry/borrow can be tested before commit
  always_comb begin
    w_cnt_ext   = {1'b0, r_count};
    w_inc       = w_cnt_ext + EXT_W'(1);
    w_dec       = w_cnt_ext - EXT_W'(1);
    w_next      = r_count;
    w_enter_acc = 1'b0;
    w_leave_acc = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case ({w_ent_evt, w_lv_evt})
      2'b10: begin
        if (w_inc <= MAX_EXT) begin
          w_next      = w_inc[CNT_W-1:0];
          w_enter_acc = 1'b1;
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!w_dec[CNT_W]) begin
          w_next      = w_dec[CNT_W-1:0];
          w_leave_acc = 1'b1;
        end else begin
          w_unf_set = 1'b1;
        end
      end
      2'b11: begin
        if (w_dec[CNT_W]) begin
          // Empty queue: the exit cannot be honoured, the entry still is
          w_next      = w_inc[CNT_W-1:0];
          w_enter_acc = 1'b1;
          w_unf_set   = 1'b1;
        end else begin
          w_enter_acc = 1'b1;
          w_leave_acc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Count, flags (from next count so they never lag) and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_enter_evt <= 1'b0;
      r_leave_evt <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_count     <= w_next;
      r_full      <= (w_next == MAX_CNT);
      r_empty     <= (w_next == '0);
      r_afull     <= (w_next >= AFULL_CNT);
      r_enter_evt <= w_enter_acc;
      r_leave_evt <= w_leave_acc;
      r_ovf       <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf       <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  assign p_count       = r_count;
  assign full_flag     = r_full;
  assign empty_flag    = r_empty;
  assign almost_full   = r_afull;
  assign enter_evt     = r_enter_evt;
  assign leave_evt     = r_leave_evt;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

`ifdef SBQM_PEAK_TRACK_EN
  logic [CNT_W-1:0] r_peak;

  // High-water mark; err_clr restarts it from the present occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak <= '0;
    end else if (err_clr) begin
      r_peak <= r_count;
    end else if (w_next > r_peak) begin
      r_peak <= w_next;
    end
  end

  assign peak_count = r_peak;
`endif

endmodule
